// File: rtl/mpu_seq_ctrl_if.sv
// I2C master command bus between the MPU6050 sequencer and the I2C engine.
interface mpu_seq_ctrl_if;
    logic       i2c_start_out;
    logic [7:0] i2c_config;
    logic [6:0] i2c_device_address;
    logic [7:0] i2c_reg_address;
    logic [7:0] i2c_write_reg_data;
    logic [7:0] i2c_data_num;
    logic       i2c_done_in;
    logic       i2c_nack_in;

    modport master (
        output i2c_start_out, i2c_config, i2c_device_address, i2c_reg_address,
               i2c_write_reg_data, i2c_data_num,
        input  i2c_done_in, i2c_nack_in
    );

    modport slave (
        input  i2c_start_out, i2c_config, i2c_device_address, i2c_reg_address,
               i2c_write_reg_data, i2c_data_num,
        output i2c_done_in, i2c_nack_in
    );
endinterface

// File: rtl/mpu_seq_ctrl.sv
// MPU6050 sequencer: table-driven config writes, calibration burst reads, then one burst read
// per timer tick, with NACK/timeout retry and an error state.
module mpu_seq_ctrl #(
    parameter logic [6:0]   DEV_ADDR       = 7'h68,
    parameter int unsigned  NUM_CFG        = 5,
    parameter logic [127:0] CFG_TABLE      = 128'h6B00_1907_1A06_1B10_1C00,
    parameter logic [7:0]   RD_REG         = 8'h3B,
    parameter logic [7:0]   RD_LEN         = 8'h0E,
    parameter int unsigned  CALIB_SAMPLES  = 1024,
    parameter int unsigned  TIMEOUT_CYCLES = 100000,
    parameter int unsigned  MAX_RETRY      = 3
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          key_flag_in,
    input  logic          timer_tick_in,
    mpu_seq_ctrl_if.master i2c,
    output logic          config_done,
    output logic          calib_done_out,
    output logic          sample_valid_out,
    output logic          timer_en_out,
    output logic          overrun_out,
    output logic          error_out
);

    typedef enum logic [3:0] {
        StIdle, StCfgIssue, StCfgWait, StCalIssue, StCalWait,
        StRunIdle, StRunIssue, StRunWait, StError
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cfg_idx_q, cfg_idx_d;
    logic [31:0] cal_cnt_q, cal_cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  retry_q, retry_d;
    logic        stop_q, stop_d;
    logic        start_q, start_d;
    logic [7:0]  cfg_q, cfg_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  num_q, num_d;
    logic        config_done_q, config_done_d;
    logic        calib_done_q, calib_done_d;
    logic        sample_q, sample_d;
    logic        timer_en_q, timer_en_d;
    logic        overrun_q, overrun_d;
    logic        error_q, error_d;

    // Entry 0 sits in the most significant used slot of the table.
    function automatic logic [15:0] cfg_entry(logic [3:0] idx);
        logic [127:0] sh;
        sh = CFG_TABLE >> (16 * (NUM_CFG - 1 - 32'(idx)));
        return sh[15:0];
    endfunction

    logic        fail, done, stop;
    logic [15:0] entry;
    state_e      retry_st;

    always_comb begin
        state_d       = state_q;
        cfg_idx_d     = cfg_idx_q;
        cal_cnt_d     = cal_cnt_q;
        retry_d       = retry_q;
        stop_d        = 1'b0;
        cfg_d         = cfg_q;
        dev_d         = dev_q;
        reg_d         = reg_q;
        wdata_d       = wdata_q;
        num_d         = num_q;
        config_done_d = config_done_q;
        calib_done_d  = calib_done_q;
        error_d       = error_q;
        sample_d      = 1'b0;
        overrun_d     = 1'b0;
        stop          = 1'b0;
        entry         = '0;

        // A simultaneous nack overrides done; a done beats a timeout in the same cycle.
        fail = i2c.i2c_nack_in ||
               (!i2c.i2c_done_in && (tmo_q == TIMEOUT_CYCLES - 1));
        done = i2c.i2c_done_in && !i2c.i2c_nack_in;

        unique case (state_q)
            StCfgWait: retry_st = StCfgIssue;
            StCalWait: retry_st = StCalIssue;
            default:   retry_st = StRunIssue;
        endcase

        tmo_d = (state_q inside {StCfgWait, StCalWait, StRunWait}) ? tmo_q + 32'd1 : 32'd0;

        unique case (state_q)
            StIdle: begin
                if (key_flag_in) begin
                    state_d       = StCfgIssue;
                    cfg_idx_d     = '0;
                    cal_cnt_d     = '0;
                    retry_d       = '0;
                    config_done_d = 1'b0;
                    calib_done_d  = 1'b0;
                    error_d       = 1'b0;
                end
            end
            StCfgIssue: state_d = StCfgWait;
            StCalIssue: state_d = StCalWait;
            StRunIdle: begin
                if (key_flag_in)        state_d = StIdle;
                else if (timer_tick_in) state_d = StRunIssue;
            end
            StRunIssue: begin
                overrun_d = timer_tick_in;
                state_d   = key_flag_in ? StIdle : StRunWait;
            end
            StCfgWait, StCalWait, StRunWait: begin
                if (state_q == StRunWait) begin
                    overrun_d = timer_tick_in;
                    stop      = stop_q || key_flag_in;
                    stop_d    = stop;
                end
                if (fail) begin
                    if (stop) begin
                        state_d = StIdle;
                    end else if (32'(retry_q) < MAX_RETRY) begin
                        retry_d = retry_q + 8'd1;
                        state_d = retry_st;
                    end else begin
                        state_d = StError;
                    end
                end else if (done) begin
                    retry_d = '0;
                    if (state_q == StCfgWait) begin
                        if (32'(cfg_idx_q) == NUM_CFG - 1) begin
                            config_done_d = 1'b1;
                            state_d       = StCalIssue;
                        end else begin
                            cfg_idx_d = cfg_idx_q + 4'd1;
                            state_d   = StCfgIssue;
                        end
                    end else if (state_q == StCalWait) begin
                        sample_d  = 1'b1;
                        cal_cnt_d = cal_cnt_q + 32'd1;
                        if (cal_cnt_d == CALIB_SAMPLES) begin
                            calib_done_d = 1'b1;
                            state_d      = StRunIdle;
                        end else begin
                            state_d = StCalIssue;
                        end
                    end else begin
                        sample_d = 1'b1;
                        state_d  = stop ? StIdle : StRunIdle;
                    end
                end
            end
            StError: begin
                if (key_flag_in) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Command fields follow the state being entered, so retries reload identical values.
        case (state_d)
            StIdle, StError: begin
                cfg_d   = 8'h00;
                dev_d   = '0;
                reg_d   = '0;
                wdata_d = '0;
                num_d   = '0;
            end
            StCfgIssue: begin
                entry   = cfg_entry(cfg_idx_d);
                cfg_d   = 8'h01;
                dev_d   = DEV_ADDR;
                reg_d   = entry[15:8];
                wdata_d = entry[7:0];
                num_d   = 8'd1;
            end
            StCalIssue, StRunIssue: begin
                cfg_d   = 8'h05;
                dev_d   = DEV_ADDR;
                reg_d   = RD_REG;
                wdata_d = 8'h00;
                num_d   = RD_LEN;
            end
            StRunIdle: cfg_d = 8'h00;
            default: ;
        endcase

        if (state_d == StError) error_d = 1'b1;
        start_d    = state_d inside {StCfgIssue, StCalIssue, StRunIssue};
        timer_en_d = state_d inside {StRunIdle, StRunIssue, StRunWait};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= StIdle;
            cfg_idx_q     <= '0;
            cal_cnt_q     <= '0;
            tmo_q         <= '0;
            retry_q       <= '0;
            stop_q        <= 1'b0;
            start_q       <= 1'b0;
            cfg_q         <= 8'h00;
            dev_q         <= '0;
            reg_q         <= '0;
            wdata_q       <= '0;
            num_q         <= '0;
            config_done_q <= 1'b0;
            calib_done_q  <= 1'b0;
            sample_q      <= 1'b0;
            timer_en_q    <= 1'b0;
            overrun_q     <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_idx_q     <= cfg_idx_d;
            cal_cnt_q     <= cal_cnt_d;
            tmo_q         <= tmo_d;
            retry_q       <= retry_d;
            stop_q        <= stop_d;
            start_q       <= start_d;
            cfg_q         <= cfg_d;
            dev_q         <= dev_d;
            reg_q         <= reg_d;
            wdata_q       <= wdata_d;
            num_q         <= num_d;
            config_done_q <= config_done_d;
            calib_done_q  <= calib_done_d;
            sample_q      <= sample_d;
            timer_en_q    <= timer_en_d;
            overrun_q     <= overrun_d;
            error_q       <= error_d;
        end
    end

    assign i2c.i2c_start_out      = start_q;
    assign i2c.i2c_config         = cfg_q;
    assign i2c.i2c_device_address = dev_q;
    assign i2c.i2c_reg_address    = reg_q;
    assign i2c.i2c_write_reg_data = wdata_q;
    assign i2c.i2c_data_num       = num_q;
    assign config_done            = config_done_q;
    assign calib_done_out         = calib_done_q;
    assign sample_valid_out       = sample_q;
    assign timer_en_out           = timer_en_q;
    assign overrun_out            = overrun_q;
    assign error_out              = error_q;

endmodule

// File: tb/tb_mpu_seq_ctrl.sv
// Scoreboard bench for mpu_seq_ctrl: expected commands are queued by the stimulus and checked by a
// monitor on every start pulse; a responder answers each start from a queue of response codes.
module tb_mpu_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic key;
    logic tick;
    logic config_done, calib_done, sample_valid, timer_en, overrun, error_o;

    always #5 clk = ~clk;

    mpu_seq_ctrl_if bus ();

    mpu_seq_ctrl #(
        .CALIB_SAMPLES  (4),
        .TIMEOUT_CYCLES (50),
        .MAX_RETRY      (3)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .key_flag_in      (key),
        .timer_tick_in    (tick),
        .i2c              (bus.master),
        .config_done      (config_done),
        .calib_done_out   (calib_done),
        .sample_valid_out (sample_valid),
        .timer_en_out     (timer_en),
        .overrun_out      (overrun),
        .error_out        (error_o)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_samples = 0;
    int n_overrun = 0;
    int cyc = 0;

    logic [38:0] exp_q[$];
    int          resp_q[$];      // 0 done, 1 nack, 2 done+nack, 3 silent
    int          start_cyc_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    endtask

    function automatic logic [38:0] mk(logic [7:0] c, logic [7:0] r, logic [7:0] d,
                                       logic [7:0] n);
        return {c, 7'h68, r, d, n};
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: compare every issued command against the scoreboard.
    always @(negedge clk) begin
        if (bus.i2c_start_out) begin
            start_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_start: got cmd %h expected none",
                         {bus.i2c_config, bus.i2c_device_address, bus.i2c_reg_address,
                          bus.i2c_write_reg_data, bus.i2c_data_num});
            end else begin
                check("cmd", 64'({bus.i2c_config, bus.i2c_device_address, bus.i2c_reg_address,
                                  bus.i2c_write_reg_data, bus.i2c_data_num}),
                      64'(exp_q.pop_front()));
            end
        end
        if (sample_valid) n_samples++;
        if (overrun) n_overrun++;
    end

    // Responder: answer each start three cycles later according to the response queue.
    int rcnt = 0;
    int rcode = 0;
    always @(negedge clk) begin
        bus.i2c_done_in = 1'b0;
        bus.i2c_nack_in = 1'b0;
        if (rst) begin
            rcnt = 0;
        end else if (bus.i2c_start_out) begin
            rcode = (resp_q.size() != 0) ? resp_q.pop_front() : 0;
            rcnt  = 3;
        end else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
                bus.i2c_done_in = (rcode == 0) || (rcode == 2);
                bus.i2c_nack_in = (rcode == 1) || (rcode == 2);
            end
        end
    end

    task automatic pulse_key();
        key = 1'b1;
        @(negedge clk);
        key = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_calib(input string name);
        for (int i = 0; i < 1000 && !calib_done; i++) @(negedge clk);
        check(name, calib_done, 1);
    endtask

    task automatic wait_sample(input string name);
        for (int i = 0; i < 200 && !sample_valid; i++) @(negedge clk);
        check(name, sample_valid, 1);
    endtask

    task automatic push_cfg(input logic [15:0] e, input int code);
        exp_q.push_back(mk(8'h01, e[15:8], e[7:0], 8'd1));
        resp_q.push_back(code);
    endtask

    task automatic push_rd(input int code);
        exp_q.push_back(mk(8'h05, 8'h3B, 8'h00, 8'h0E));
        resp_q.push_back(code);
    endtask

    logic [15:0] tab [5] = '{16'h6B00, 16'h1907, 16'h1A06, 16'h1B10, 16'h1C00};
    int base;

    initial begin
        rst  = 1'b1;
        key  = 1'b0;
        tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start", bus.i2c_start_out, 0);
        check("rst_config", bus.i2c_config, 8'h00);
        check("rst_dev", bus.i2c_device_address, 0);
        check("rst_flags", {config_done, calib_done, sample_valid, timer_en, overrun, error_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Clean bring-up: five writes then four calibration reads.
        for (int i = 0; i < 5; i++) push_cfg(tab[i], 0);
        for (int i = 0; i < 4; i++) push_rd(0);
        pulse_key();
        wait_calib("calib_done_a");
        check("timer_en_with_calib", timer_en, 1);
        check("sample_with_calib", sample_valid, 1);
        check("config_done_a", config_done, 1);
        @(negedge clk);
        check("samples_a", n_samples, 4);
        check("queue_a", exp_q.size(), 0);

        // RUN: second tick while the read is outstanding is dropped and reported.
        push_rd(0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("overrun_pulse", overrun, 1);
        wait_sample("run_sample1");
        check("timer_en_run", timer_en, 1);
        check("idle_cfg_run", bus.i2c_config, 8'h00);

        // Key during RUN_WAIT: completes the read, then stops.
        push_rd(0);
        pulse_tick();
        @(negedge clk);
        pulse_key();
        wait_sample("run_sample2");
        check("timer_en_stop", timer_en, 0);
        @(negedge clk);
        check("idle_config", bus.i2c_config, 8'h00);
        check("idle_dev", bus.i2c_device_address, 0);
        pulse_tick();
        repeat (5) @(negedge clk);
        check("samples_run", n_samples, 6);
        check("overrun_count", n_overrun, 1);
        check("queue_run", exp_q.size(), 0);

        // Nack twice on the second write; done+nack on the second calibration read.
        push_cfg(tab[0], 0);
        push_cfg(tab[1], 1);
        push_cfg(tab[1], 1);
        push_cfg(tab[1], 0);
        for (int i = 2; i < 5; i++) push_cfg(tab[i], 0);
        push_rd(0);
        push_rd(2);
        push_rd(0);
        push_rd(0);
        push_rd(0);
        base = n_samples;
        pulse_key();
        wait_calib("calib_done_b");
        check("error_b", error_o, 0);
        @(negedge clk);
        check("samples_b", n_samples, base + 4);
        check("queue_b", exp_q.size(), 0);
        pulse_key();
        check("timer_en_b", timer_en, 0);

        // Silent slave: four attempts 51 cycles apart, then ERROR.
        start_cyc_q.delete();
        for (int i = 0; i < 4; i++) push_cfg(tab[0], 3);
        pulse_key();
        for (int i = 0; i < 400 && !error_o; i++) @(negedge clk);
        check("error_set", error_o, 1);
        check("error_config", bus.i2c_config, 8'h00);
        check("timeout_starts", start_cyc_q.size(), 4);
        for (int i = 1; i < 4 && i < start_cyc_q.size(); i++)
            check("timeout_gap", start_cyc_q[i] - start_cyc_q[i-1], 51);
        repeat (3) @(negedge clk);
        check("error_no_start", exp_q.size(), 0);
        pulse_key();
        check("idle_after_err", bus.i2c_config, 8'h00);

        // Restart clears error; reset mid-transaction returns to IDLE silently.
        push_cfg(tab[0], 0);
        pulse_key();
        check("error_cleared", error_o, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_start", bus.i2c_start_out, 0);
        check("rst_mid_config", bus.i2c_config, 8'h00);
        check("rst_mid_dev", bus.i2c_device_address, 0);
        check("rst_mid_done", {config_done, calib_done, timer_en}, 0);
        repeat (10) @(negedge clk);
        check("queue_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
